// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// opcodes, FSM state codes, ALUOp codes and the control bundle.
package mips_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FSM state codes
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    // ALUOp codes for the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control bundle driven to the datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Output decode for the multicycle control FSM: Moore outputs per
// state, plus the ready-dependent strobes of FETCH and MEMWR.
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic [5:0] opcode,
    input  logic       rdy,
    output ctrl_t      ctrl
);

    // Map the current state to the datapath control bundle
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = rdy;
                ctrl.ir_write  = rdy;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.illegal_op = !op_supported(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = rdy;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (op_q == OP_BNE);
                ctrl.instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// latched opcode and next-state sequencing per instruction class.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_next;
    logic [5:0] op_q;
    logic       rdy;
    ctrl_t      ctrl;

    // Reset masks ready so that no Mealy strobe fires while held in reset
    assign rdy = (mem_ready | ~USE_MEM_READY) & ~reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Opcode is captured in DECODE; later states steer on this copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_FETCH: begin
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_ADDI:       state_next = S_ADDIEX;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR: begin
                if (rdy) state_next = S_FETCH;
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .state  (state_q),
        .op_q   (op_q),
        .opcode (opcode),
        .rdy    (rdy),
        .ctrl   (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state walks,
// stall handling, illegal opcodes and asynchronous reset abort.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int fails  = 0;

    multicycle_control #(.USE_MEM_READY(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_RTYPE;
        #1;
        checks++;
        if (state !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if ({mem_read, alu_src_b} !== 3'b101) begin
            fails++;
            $display("FAIL reset_fetch_out: got %b expected 101", {mem_read, alu_src_b});
        end
        checks++;
        if ({pc_write, ir_write, mem_write, reg_write, instr_done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {pc_write, ir_write, mem_write, reg_write, instr_done});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6];
        int done_cnt;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        done_cnt = 0;
        opcode = OP_LW;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                fails++;
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
            end
            checks++;
            if ({reg_write, mem_to_reg} !== {2{exp_st[i] == 4'd4}}) begin
                fails++;
                $display("FAIL lw_wb[%0d]: got %b expected %b", i,
                         {reg_write, mem_to_reg}, {2{exp_st[i] == 4'd4}});
            end
            if (exp_st[i] == 4'd3) begin
                checks++;
                if ({mem_read, i_or_d, mem_write} !== 3'b110) begin
                    fails++;
                    $display("FAIL lw_memrd: got %b expected 110", {mem_read, i_or_d, mem_write});
                end
            end
            if (instr_done === 1'b1) done_cnt++;
            if (i < 5) @(negedge clk);
        end
        checks++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL lw_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_fetch_stall();
        opcode = OP_J;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state, pc_write, ir_write, mem_read} !== {4'd0, 3'b001}) begin
                fails++;
                $display("FAIL stall_fetch[%0d]: got st=%0d pcw=%b irw=%b mr=%b expected st=0 pcw=0 irw=0 mr=1",
                         i, state, pc_write, ir_write, mem_read);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, pc_write, ir_write} !== {4'd0, 2'b11}) begin
            fails++;
            $display("FAIL stall_release: got st=%0d pcw=%b irw=%b expected st=0 pcw=1 irw=1",
                     state, pc_write, ir_write);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin
            fails++;
            $display("FAIL stall_decode: got %0d expected 1", state);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({state, pc_write, pc_source, instr_done} !== {4'd11, 1'b1, 2'b10, 1'b1}) begin
            fails++;
            $display("FAIL jump_out: got st=%0d pcw=%b src=%b done=%b expected st=11 pcw=1 src=10 done=1",
                     state, pc_write, pc_source, instr_done);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = OP_RTYPE;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                fails++;
                $display("FAIL r_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 4'd6) begin
                checks++;
                if ({alu_op, alu_src_a, reg_write} !== 4'b1010) begin
                    fails++;
                    $display("FAIL r_exec: got %b expected 1010", {alu_op, alu_src_a, reg_write});
                end
            end
            if (exp_st[i] == 4'd7) begin
                checks++;
                if ({reg_dst, reg_write, instr_done, mem_to_reg} !== 4'b1110) begin
                    fails++;
                    $display("FAIL r_aluwb: got %b expected 1110",
                             {reg_dst, reg_write, instr_done, mem_to_reg});
                end
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        ops = '{OP_BEQ, OP_BNE};
        mem_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            opcode = ops[j];
            #1;
            checks++;
            if (state !== 4'd0) begin
                fails++;
                $display("FAIL br_start[%0d]: got %0d expected 0", j, state);
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (state !== 4'd8) begin
                fails++;
                $display("FAIL br_state[%0d]: got %0d expected 8", j, state);
            end
            checks++;
            if ({alu_op, pc_write_cond, pc_source, branch_ne, instr_done, pc_write} !==
                {2'b01, 1'b1, 2'b01, j[0], 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL br_out[%0d]: got aluop=%b pwc=%b src=%b bne=%b done=%b pcw=%b expected aluop=01 pwc=1 src=01 bne=%0d done=1 pcw=0",
                         j, alu_op, pc_write_cond, pc_source, branch_ne, instr_done, pc_write, j);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_st [3];
        exp_st = '{4'd0, 4'd1, 4'd0};
        opcode = 6'b111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                fails++;
                $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
            end
            checks++;
            if ({illegal_op, reg_write, mem_write} !== {(i == 1), 2'b00}) begin
                fails++;
                $display("FAIL ill_out[%0d]: got %b expected %b", i,
                         {illegal_op, reg_write, mem_write}, {(i == 1), 2'b00});
            end
            if (i < 2) @(negedge clk);
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp_st [6];
        logic       rdy_v  [6];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
        rdy_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy_v[i];
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                fails++;
                $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 4'd5) begin
                checks++;
                if ({mem_write, mem_read, i_or_d, instr_done} !== {3'b101, rdy_v[i]}) begin
                    fails++;
                    $display("FAIL sw_memwr[%0d]: got %b expected %b", i,
                             {mem_write, mem_read, i_or_d, instr_done}, {3'b101, rdy_v[i]});
                end
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_addi();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        opcode = OP_ADDI;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                fails++;
                $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 4'd9) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== 5'b11000) begin
                    fails++;
                    $display("FAIL addi_ex: got %b expected 11000", {alu_src_a, alu_src_b, alu_op});
                end
            end
            if (exp_st[i] == 4'd10) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin
                    fails++;
                    $display("FAIL addi_wb: got %b expected 1001",
                             {reg_write, reg_dst, mem_to_reg, instr_done});
                end
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        opcode = OP_SW;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({state, mem_write} !== {4'd5, 1'b1}) begin
            fails++;
            $display("FAIL rst_mid_pre: got st=%0d mw=%b expected st=5 mw=1", state, mem_write);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, mem_write, mem_read, pc_write} !== {4'd0, 3'b010}) begin
            fails++;
            $display("FAIL rst_mid_abort: got st=%0d mw=%b mr=%b pcw=%b expected st=0 mw=0 mr=1 pcw=0",
                     state, mem_write, mem_read, pc_write);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_fetch_stall();
        test_rtype();
        test_branch();
        test_illegal();
        test_sw_stall();
        test_addi();
        test_reset_mid();
        test_lw();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
